alu_cmd_issuer: RTL

- Bus-side master for the 8-bit Booth/NRD ALU.
- Accepts operation requests (opcode, two 8-bit operands) on a valid/ready interface and packs each into the ALU's 18-bit code word.
- Starts the ALU with a one-cycle ALU reset, waits for the ALU's stop, then captures the 16-bit result and flags.
- Returns results in order through a small result FIFO, with a timeout guard against a hung ALU.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_cmd_issuer_res_fifo.sv | 52 +++++
 rtl/alu_cmd_issuer.sv | 104 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer:
// opcodes, code-word fields, result layout, FSM states.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int CODE_W = 18;
  localparam int Q_MSB  = 17;
  localparam int Q_LSB  = 10;
  localparam int M_MSB  = 9;
  localparam int M_LSB  = 2;
  localparam int OP_MSB = 1;

  localparam int RES_W       = 19;
  localparam int TIMEOUT_BIT = 18;
  localparam int OVF_BIT     = 17;
  localparam int ZERO_BIT    = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALURST,
    ST_RUN,
    ST_CAPTURE
  } state_t;

  function automatic logic [CODE_W-1:0] pack_code(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [1:0] op
  );
    logic [CODE_W-1:0] c;
    c = '0;
    c[Q_MSB:Q_LSB]  = a;
    c[M_MSB:M_LSB]  = b;
    c[OP_MSB:0]     = op;
    return c;
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_res_fifo.sv
// Synchronous FIFO holding captured ALU results.
// Head is presented combinationally; empty reads as zero.
module res_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Bus-side master for the 8-bit Booth/NRD ALU: packs a command,
// pulses the ALU reset, waits for stop and queues the result.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int RES_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [7:0]        cmd_a,
  input  logic [7:0]        cmd_b,
  output logic [CODE_W-1:0] alu_code,
  output logic              alu_rst,
  input  logic              alu_stop,
  input  logic [15:0]       alu_rez,
  input  logic              alu_zero,
  input  logic              alu_ovf,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              busy
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CW = $clog2(RES_DEPTH + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           state_nx;
  logic [TW-1:0]    timer;
  logic [RES_W-1:0] cap_q;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             timer_last;
  logic             accept;
  logic             push;

  assign timer_last = (timer == TIMER_LAST);
  assign accept     = cmd_valid & cmd_ready;
  assign alu_rst    = rst | (state == ST_ALURST);
  assign busy       = (state != ST_IDLE);
  assign res_valid  = ~fifo_empty;

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    push      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = ~rst & (fifo_count < CW'(RES_DEPTH));
        if (cmd_valid & cmd_ready) state_nx = ST_ALURST;
      end
      ST_ALURST: state_nx = ST_RUN;
      ST_RUN: begin
        if (alu_stop | timer_last) state_nx = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        push     = ~fifo_full;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      alu_code <= '0;
      timer    <= '0;
      cap_q    <= '0;
    end else begin
      state <= state_nx;
      if (accept) alu_code <= pack_code(cmd_a, cmd_b, cmd_op);
      if (state == ST_ALURST) begin
        timer <= '0;
      end else if (state == ST_RUN) begin
        // stop wins over timeout when both land in the same cycle
        cap_q <= {~alu_stop & timer_last, alu_ovf, alu_zero, alu_rez};
        if (!alu_stop && !timer_last) timer <= timer + TW'(1);
      end
    end
  end

  res_fifo #(
    .W     (RES_W),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (cap_q),
    .pop   (res_valid & res_ready),
    .rdata (res_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule
